// File: rtl/pipeline_condlogic.sv
// Condition-and-control pipeline for the ARM core: carries the decoded control bundle
// through E, M and W, predicates it on Cond[31:28] against the flags, and maintains FlagsQ.
module pipeline_condlogic #(
    parameter bit         COND_EN     = 1'b1,
    parameter int         REG_ADDR_W  = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic [3:0]            CondD,
    input  logic                  PCSD,
    input  logic                  RegWD,
    input  logic                  MemWD,
    input  logic [1:0]            FlagWD,
    input  logic                  MemtoRegD,
    input  logic                  BranchD,
    input  logic                  BLD,
    input  logic [REG_ADDR_W-1:0] WA3D,
    input  logic [3:0]            ALUFlagsE,
    output logic                  CondExE,
    output logic                  BranchTakenE,
    output logic [3:0]            FlagsQ,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  MemtoRegM,
    output logic [REG_ADDR_W-1:0] WA3M,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic                  PCSrcW,
    output logic                  BLW,
    output logic [REG_ADDR_W-1:0] WA3W
);

    typedef struct packed {
        logic                  pcs;
        logic                  regw;
        logic                  memw;
        logic [1:0]            flagw;
        logic                  mtr;
        logic                  branch;
        logic                  bl;
        logic [REG_ADDR_W-1:0] wa3;
        logic [3:0]            cond;
    } ectl_t;

    ectl_t                  e_q, e_d, d_bundle;
    logic [3:0]             flags_q, flags_d;
    logic                   cond_pass;
    logic                   cond_ex;
    logic                   regw_m_q, regw_m_d;
    logic                   memw_m_q, memw_m_d;
    logic                   mtr_m_q, mtr_m_d;
    logic                   pcs_m_q, pcs_m_d;
    logic                   bl_m_q, bl_m_d;
    logic [REG_ADDR_W-1:0]  wa3_m_q, wa3_m_d;
    logic                   regw_w_q, mtr_w_q, pcs_w_q, bl_w_q;
    logic [REG_ADDR_W-1:0]  wa3_w_q;

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        d_bundle.pcs    = PCSD;
        d_bundle.regw   = RegWD;
        d_bundle.memw   = MemWD;
        d_bundle.flagw  = FlagWD;
        d_bundle.mtr    = MemtoRegD;
        d_bundle.branch = BranchD;
        d_bundle.bl     = BLD;
        d_bundle.wa3    = WA3D;
        d_bundle.cond   = CondD;
    end

    // Flush beats stall so a squashed instruction can never be held in E.
    always_comb begin
        if (FlushE)      e_d = '0;
        else if (StallE) e_d = e_q;
        else             e_d = d_bundle;
    end

    always_comb begin
        cond_pass = 1'b0;
        case (e_q.cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex = COND_EN ? cond_pass : 1'b1;

    // Flags follow the E instruction only when it actually advances out of E.
    always_comb begin
        flags_d = flags_q;
        if (!StallE && cond_ex) begin
            if (e_q.flagw[1]) flags_d[3:2] = ALUFlagsE[3:2];
            if (e_q.flagw[0]) flags_d[1:0] = ALUFlagsE[1:0];
        end
    end

    always_comb begin
        regw_m_d = 1'b0;
        memw_m_d = 1'b0;
        mtr_m_d  = 1'b0;
        pcs_m_d  = 1'b0;
        bl_m_d   = 1'b0;
        wa3_m_d  = '0;
        if (!StallE) begin
            regw_m_d = e_q.regw & cond_ex;
            memw_m_d = e_q.memw & cond_ex;
            mtr_m_d  = e_q.mtr;
            pcs_m_d  = e_q.pcs & cond_ex;
            bl_m_d   = e_q.bl & cond_ex;
            wa3_m_d  = e_q.wa3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q      <= '0;
            flags_q  <= RESET_FLAGS;
            regw_m_q <= 1'b0;
            memw_m_q <= 1'b0;
            mtr_m_q  <= 1'b0;
            pcs_m_q  <= 1'b0;
            bl_m_q   <= 1'b0;
            wa3_m_q  <= '0;
            regw_w_q <= 1'b0;
            mtr_w_q  <= 1'b0;
            pcs_w_q  <= 1'b0;
            bl_w_q   <= 1'b0;
            wa3_w_q  <= '0;
        end else begin
            e_q      <= e_d;
            flags_q  <= flags_d;
            regw_m_q <= regw_m_d;
            memw_m_q <= memw_m_d;
            mtr_m_q  <= mtr_m_d;
            pcs_m_q  <= pcs_m_d;
            bl_m_q   <= bl_m_d;
            wa3_m_q  <= wa3_m_d;
            regw_w_q <= regw_m_q;
            mtr_w_q  <= mtr_m_q;
            pcs_w_q  <= pcs_m_q;
            bl_w_q   <= bl_m_q;
            wa3_w_q  <= wa3_m_q;
        end
    end

    assign CondExE      = cond_ex;
    assign BranchTakenE = e_q.branch & cond_ex;
    assign FlagsQ       = flags_q;
    assign RegWriteM    = regw_m_q;
    assign MemWriteM    = memw_m_q;
    assign MemtoRegM    = mtr_m_q;
    assign WA3M         = wa3_m_q;
    assign RegWriteW    = regw_w_q;
    assign MemtoRegW    = mtr_w_q;
    assign PCSrcW       = pcs_w_q;
    assign BLW          = bl_w_q;
    assign WA3W         = wa3_w_q;

endmodule

// File: tb/tb_pipeline_condlogic.sv
// Directed bench for pipeline_condlogic: a predicated instance plus a COND_EN=0 instance.
module tb_pipeline_condlogic;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_stall, d_flush;
    logic [3:0] d_cond;
    logic       d_pcs, d_regw, d_memw, d_mtr, d_br, d_bl;
    logic [1:0] d_flagw;
    logic [3:0] d_wa3;
    logic [3:0] d_alu;

    logic       CondExE, BranchTakenE, RegWriteM, MemWriteM, MemtoRegM;
    logic       RegWriteW, MemtoRegW, PCSrcW, BLW;
    logic [3:0] FlagsQ, WA3M, WA3W;

    logic       CondExE_1, BranchTakenE_1, RegWriteM_1, MemWriteM_1, MemtoRegM_1;
    logic       RegWriteW_1, MemtoRegW_1, PCSrcW_1, BLW_1;
    logic [3:0] FlagsQ_1, WA3M_1, WA3W_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_condlogic #(.COND_EN(1'b1), .REG_ADDR_W(4), .RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .reset(reset), .StallE(d_stall), .FlushE(d_flush),
        .CondD(d_cond), .PCSD(d_pcs), .RegWD(d_regw), .MemWD(d_memw), .FlagWD(d_flagw),
        .MemtoRegD(d_mtr), .BranchD(d_br), .BLD(d_bl), .WA3D(d_wa3), .ALUFlagsE(d_alu),
        .CondExE(CondExE), .BranchTakenE(BranchTakenE), .FlagsQ(FlagsQ),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .WA3M(WA3M),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .BLW(BLW), .WA3W(WA3W)
    );

    pipeline_condlogic #(.COND_EN(1'b0), .REG_ADDR_W(4), .RESET_FLAGS(4'b0100)) dut_nc (
        .clk(clk), .reset(reset), .StallE(d_stall), .FlushE(d_flush),
        .CondD(d_cond), .PCSD(d_pcs), .RegWD(d_regw), .MemWD(d_memw), .FlagWD(d_flagw),
        .MemtoRegD(d_mtr), .BranchD(d_br), .BLD(d_bl), .WA3D(d_wa3), .ALUFlagsE(d_alu),
        .CondExE(CondExE_1), .BranchTakenE(BranchTakenE_1), .FlagsQ(FlagsQ_1),
        .RegWriteM(RegWriteM_1), .MemWriteM(MemWriteM_1), .MemtoRegM(MemtoRegM_1), .WA3M(WA3M_1),
        .RegWriteW(RegWriteW_1), .MemtoRegW(MemtoRegW_1), .PCSrcW(PCSrcW_1), .BLW(BLW_1), .WA3W(WA3W_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        d_cond = 4'b0000; d_pcs = 1'b0; d_regw = 1'b0; d_memw = 1'b0; d_flagw = 2'b00;
        d_mtr = 1'b0; d_br = 1'b0; d_bl = 1'b0; d_wa3 = 4'd0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; d_stall = 1'b0; d_flush = 1'b0; d_alu = 4'b0000;
        clear_d();
        tick(); tick();
        total++; if (FlagsQ !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", FlagsQ); end
        total++; if (FlagsQ_1 !== 4'b0100) begin bad++; $display("FAIL rst_flags_nc got=%b exp=0100", FlagsQ_1); end
        total++; if ({RegWriteM, MemWriteM, MemtoRegM, WA3M} !== 7'd0) begin bad++; $display("FAIL rst_m got=%b exp=0", {RegWriteM, MemWriteM, MemtoRegM, WA3M}); end
        total++; if ({RegWriteW, MemtoRegW, PCSrcW, BLW, WA3W} !== 8'd0) begin bad++; $display("FAIL rst_w got=%b exp=0", {RegWriteW, MemtoRegW, PCSrcW, BLW, WA3W}); end
        total++; if ({CondExE, BranchTakenE} !== 2'b00) begin bad++; $display("FAIL rst_e got=%b exp=00", {CondExE, BranchTakenE}); end
        reset = 1'b0;
        $display("reset: flags=%b flags_nc=%b", FlagsQ, FlagsQ_1);
    endtask

    task automatic test_reset_mid();
        d_cond = 4'b1110; d_regw = 1'b1; d_memw = 1'b1; d_wa3 = 4'd6; d_flagw = 2'b11; d_alu = 4'b1111;
        tick(); tick();
        total++; if (RegWriteM !== 1'b1) begin bad++; $display("FAIL mid_pre_regwm got=%b exp=1", RegWriteM); end
        total++; if (FlagsQ !== 4'b1111) begin bad++; $display("FAIL mid_pre_flags got=%b exp=1111", FlagsQ); end
        #2; reset = 1'b1; #1;
        total++; if ({RegWriteM, MemWriteM, WA3M} !== 6'd0) begin bad++; $display("FAIL mid_async_m got=%b exp=0", {RegWriteM, MemWriteM, WA3M}); end
        total++; if (FlagsQ !== 4'b0000) begin bad++; $display("FAIL mid_async_flags got=%b exp=0000", FlagsQ); end
        total++; if ({CondExE, BranchTakenE, RegWriteW} !== 3'b000) begin bad++; $display("FAIL mid_async_ew got=%b exp=000", {CondExE, BranchTakenE, RegWriteW}); end
        tick(); tick();
        total++; if ({RegWriteM, RegWriteW, MemWriteM} !== 3'b000) begin bad++; $display("FAIL mid_held_mw got=%b exp=000", {RegWriteM, RegWriteW, MemWriteM}); end
        total++; if (FlagsQ !== 4'b0000) begin bad++; $display("FAIL mid_held_flags got=%b exp=0000", FlagsQ); end
        reset = 1'b0;
        clear_d();
        $display("reset_mid: regwm=%b flags=%b", RegWriteM, FlagsQ);
    endtask

    task automatic test_flags_branch();
        d_flagw = 2'b11; d_cond = 4'b1110; d_alu = 4'b0100;
        tick();
        total++; if (CondExE !== 1'b1) begin bad++; $display("FAIL fb_condex got=%b exp=1", CondExE); end
        clear_d(); d_br = 1'b1; d_cond = 4'b0000;
        tick();
        total++; if (FlagsQ !== 4'b0100) begin bad++; $display("FAIL fb_flags got=%b exp=0100", FlagsQ); end
        total++; if (BranchTakenE !== 1'b1) begin bad++; $display("FAIL fb_btaken got=%b exp=1", BranchTakenE); end
        clear_d();
        $display("flags_branch: flags=%b btaken=%b", FlagsQ, BranchTakenE);
    endtask

    task automatic test_gating();
        pulse_reset(); clear_d();
        d_regw = 1'b1; d_cond = 4'b0000; d_wa3 = 4'd5;
        tick();
        total++; if (CondExE !== 1'b0) begin bad++; $display("FAIL g_addeq_condex got=%b exp=0", CondExE); end
        clear_d(); tick();
        total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL g_addeq_regwm got=%b exp=0", RegWriteM); end
        total++; if (WA3M !== 4'd5) begin bad++; $display("FAIL g_addeq_wa3m got=%0d exp=5", WA3M); end
        tick();
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL g_addeq_regww got=%b exp=0", RegWriteW); end
        d_regw = 1'b1; d_cond = 4'b0001; d_wa3 = 4'd3;
        tick(); clear_d(); tick();
        total++; if ({RegWriteM, WA3M} !== {1'b1, 4'd3}) begin bad++; $display("FAIL g_ne_m got=%b exp=10011", {RegWriteM, WA3M}); end
        tick();
        total++; if ({RegWriteW, WA3W} !== {1'b1, 4'd3}) begin bad++; $display("FAIL g_ne_w got=%b exp=10011", {RegWriteW, WA3W}); end
        d_cond = 4'b1110; d_pcs = 1'b1; d_bl = 1'b1; d_memw = 1'b1; d_mtr = 1'b1; d_regw = 1'b1; d_wa3 = 4'd14;
        tick(); clear_d(); tick();
        total++; if ({MemWriteM, MemtoRegM} !== 2'b11) begin bad++; $display("FAIL g_al_m got=%b exp=11", {MemWriteM, MemtoRegM}); end
        tick();
        total++; if ({PCSrcW, BLW, MemtoRegW} !== 3'b111) begin bad++; $display("FAIL g_al_w got=%b exp=111", {PCSrcW, BLW, MemtoRegW}); end
        d_cond = 4'b0000; d_pcs = 1'b1; d_bl = 1'b1; d_memw = 1'b1; d_mtr = 1'b1; d_br = 1'b1; d_wa3 = 4'd14;
        tick();
        total++; if (BranchTakenE !== 1'b0) begin bad++; $display("FAIL g_fail_btaken got=%b exp=0", BranchTakenE); end
        clear_d(); tick();
        total++; if ({MemWriteM, MemtoRegM} !== 2'b01) begin bad++; $display("FAIL g_fail_m got=%b exp=01", {MemWriteM, MemtoRegM}); end
        tick();
        total++; if ({PCSrcW, BLW, MemtoRegW} !== 3'b001) begin bad++; $display("FAIL g_fail_w got=%b exp=001", {PCSrcW, BLW, MemtoRegW}); end
        $display("gating: pcsw=%b blw=%b mtrw=%b", PCSrcW, BLW, MemtoRegW);
    endtask

    task automatic test_cond_table();
        logic [15:0] exp_1100;
        logic [15:0] exp_0011;
        exp_1100 = 16'b0110_1010_1001_1001;   // bit c = expected CondExE for cond c, NZCV=1100
        exp_0011 = 16'b0110_1001_0110_0110;   // NZCV=0011
        d_flagw = 2'b10; d_alu = 4'b1111; d_cond = 4'b1110;
        tick(); clear_d(); tick();
        total++; if (FlagsQ !== 4'b1100) begin bad++; $display("FAIL ct_nz_only got=%b exp=1100", FlagsQ); end
        for (int c = 0; c < 16; c++) begin
            d_cond = c[3:0]; tick();
            total++; if (CondExE !== exp_1100[c]) begin bad++; $display("FAIL ct_1100_c%0d got=%b exp=%b", c, CondExE, exp_1100[c]); end
        end
        clear_d();
        d_flagw = 2'b01; d_alu = 4'b0011; d_cond = 4'b1110;
        tick(); clear_d(); tick();
        total++; if (FlagsQ !== 4'b1111) begin bad++; $display("FAIL ct_cv_only got=%b exp=1111", FlagsQ); end
        d_flagw = 2'b11; d_alu = 4'b0011; d_cond = 4'b1110;
        tick(); clear_d(); tick();
        total++; if (FlagsQ !== 4'b0011) begin bad++; $display("FAIL ct_both got=%b exp=0011", FlagsQ); end
        for (int c = 0; c < 16; c++) begin
            d_cond = c[3:0]; tick();
            total++; if (CondExE !== exp_0011[c]) begin bad++; $display("FAIL ct_0011_c%0d got=%b exp=%b", c, CondExE, exp_0011[c]); end
        end
        clear_d();
        d_flagw = 2'b11; d_alu = 4'b1111; d_cond = 4'b0000;
        tick(); clear_d(); tick();
        total++; if (FlagsQ !== 4'b0011) begin bad++; $display("FAIL ct_blocked got=%b exp=0011", FlagsQ); end
        $display("cond_table: flags=%b", FlagsQ);
    endtask

    task automatic test_stall_flush();
        d_flagw = 2'b11; d_cond = 4'b1110; d_alu = 4'b1000; d_regw = 1'b1; d_wa3 = 4'd7;
        tick();
        clear_d(); d_regw = 1'b1; d_cond = 4'b1110; d_wa3 = 4'd9;
        d_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL sf_bubble%0d got=%b exp=0", k, RegWriteM); end
            total++; if (FlagsQ !== 4'b0011) begin bad++; $display("FAIL sf_flags_hold%0d got=%b exp=0011", k, FlagsQ); end
        end
        d_stall = 1'b0;
        tick();
        total++; if (FlagsQ !== 4'b1000) begin bad++; $display("FAIL sf_flags_rel got=%b exp=1000", FlagsQ); end
        total++; if ({RegWriteM, WA3M} !== {1'b1, 4'd7}) begin bad++; $display("FAIL sf_held_m got=%b exp=10111", {RegWriteM, WA3M}); end
        clear_d(); d_br = 1'b1; d_cond = 4'b1110;
        d_stall = 1'b1; d_flush = 1'b1;
        tick();
        total++; if ({CondExE, BranchTakenE} !== 2'b00) begin bad++; $display("FAIL sf_flush_e got=%b exp=00", {CondExE, BranchTakenE}); end
        total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL sf_flush_m got=%b exp=0", RegWriteM); end
        d_stall = 1'b0; d_flush = 1'b0; clear_d();
        tick();
        total++; if ({RegWriteM, WA3M} !== 5'd0) begin bad++; $display("FAIL sf_after_flush got=%b exp=00000", {RegWriteM, WA3M}); end
        $display("stall_flush: flags=%b regwm=%b", FlagsQ, RegWriteM);
    endtask

    task automatic test_nv_nocond();
        pulse_reset(); clear_d();
        d_cond = 4'b1111; d_regw = 1'b1; d_br = 1'b1;
        tick();
        total++; if (CondExE !== 1'b0) begin bad++; $display("FAIL nv_condex got=%b exp=0", CondExE); end
        total++; if ({CondExE_1, BranchTakenE_1} !== 2'b11) begin bad++; $display("FAIL nv_nocond got=%b exp=11", {CondExE_1, BranchTakenE_1}); end
        d_cond = 4'b0001;
        tick();
        total++; if (CondExE_1 !== 1'b1) begin bad++; $display("FAIL ne_z1_nocond got=%b exp=1", CondExE_1); end
        total++; if (CondExE !== 1'b1) begin bad++; $display("FAIL ne_z0 got=%b exp=1", CondExE); end
        clear_d();
        $display("nv_nocond: condex=%b condex_nc=%b flags_nc=%b", CondExE, CondExE_1, FlagsQ_1);
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            d_regw = 1'b1; d_cond = 4'b1110; d_wa3 = i[3:0];
            tick();
            if (i >= 2) begin
                total++; if (WA3M !== 4'(i - 1)) begin bad++; $display("FAIL b2b_wa3m_%0d got=%0d exp=%0d", i, WA3M, i - 1); end
            end
            if (i >= 3) begin
                total++; if (WA3W !== 4'(i - 2)) begin bad++; $display("FAIL b2b_wa3w_%0d got=%0d exp=%0d", i, WA3W, i - 2); end
            end
        end
        clear_d(); tick();
        total++; if ({WA3M, WA3W} !== {4'd4, 4'd3}) begin bad++; $display("FAIL b2b_tail1 got=%h exp=43", {WA3M, WA3W}); end
        tick();
        total++; if ({RegWriteW, WA3W} !== {1'b1, 4'd4}) begin bad++; $display("FAIL b2b_tail2 got=%b exp=10100", {RegWriteW, WA3W}); end
        $display("back_to_back: wa3m=%0d wa3w=%0d", WA3M, WA3W);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_flags_branch();
        test_gating();
        test_cond_table();
        test_stall_flush();
        test_nv_nocond();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
